// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, forwarding select and hazard FSM states.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  localparam int LC3B_NUM_STAGES = 2;
  localparam int LC3B_SEL_W      = $clog2(LC3B_NUM_STAGES + 1);

  typedef logic [LC3B_SEL_W-1:0] lc3b_fwd_sel;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } fwd_fsm_t;

  localparam int FWD_SEL_REGFILE = 0;

endpackage

// File: rtl/fwd_src_match.sv
// One source operand against every downstream stage: youngest-match select, zero latency.
// No flow control; purely combinational.
module fwd_src_match
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int REG_W      = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_W-1:0]            src_reg,
  input  logic                        src_used,
  input  logic [NUM_STAGES*REG_W-1:0] stage_dest,
  input  logic [NUM_STAGES-1:0]       stage_write,
  output logic [SEL_W-1:0]            sel,
  output logic                        sel_is_s1
);

  // Walk oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    sel = SEL_W'(FWD_SEL_REGFILE);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (src_used && stage_write[k] &&
          (src_reg == stage_dest[k*REG_W +: REG_W])) begin
        sel = SEL_W'(k + 1);
      end
    end
    sel_is_s1 = (sel == SEL_W'(1));
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding selects plus load-use stall FSM and watchdog; optional perf counters (FWD_PERF_CNT_EN).
// Selects are zero-latency; stall holds the front end until mem_resp, watchdog flags long waits.
module forward_hazard_unit
  import lc3b_types::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int REG_W      = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1),
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC*REG_W-1:0]    src_reg,
  input  logic [NUM_SRC-1:0]          src_used,
  input  logic                        ex_valid,
  input  logic [NUM_STAGES*REG_W-1:0] stage_dest,
  input  logic [NUM_STAGES-1:0]       stage_write,
  input  logic [NUM_STAGES-1:0]       stage_is_load,
  input  logic                        mem_resp,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic                        bubble,
  output logic                        hazard_timeout,
  output logic [31:0]                 perf_fwd_cnt,
  output logic [31:0]                 perf_stall_cnt
);

  localparam int          WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic [NUM_SRC-1:0] src_is_s1;
  logic               hazard;
  logic               unused_load_hi;

  fwd_fsm_t        state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .NUM_STAGES (NUM_STAGES),
      .REG_W      (REG_W),
      .SEL_W      (SEL_W)
    ) u_match (
      .src_reg     (src_reg[i*REG_W +: REG_W]),
      .src_used    (src_used[i]),
      .stage_dest  (stage_dest),
      .stage_write (stage_write),
      .sel         (fwd_sel[i*SEL_W +: SEL_W]),
      .sel_is_s1   (src_is_s1[i])
    );
  end

  // Loads in stage 2 or older already have data, so only the stage-1 flag matters.
  assign unused_load_hi = ^stage_is_load;
  assign hazard         = ex_valid && (|src_is_s1) && stage_is_load[0];

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    unique case (state_q)
      RUN: begin
        wd_d = '0;
        if (hazard) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = mem_resp ? RELEASE : WAIT;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + WD_W'(1);
        end else begin
          timeout_d = 1'b1;
        end
        if (mem_resp) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A new hazard seen here is picked up by RUN on the following cycle.
        wd_d    = '0;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign hazard_timeout = timeout_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_fwd_q, perf_fwd_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] fwd_events;

  always_comb begin
    fwd_events = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_valid && !stall &&
          (fwd_sel[i*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_REGFILE))) begin
        fwd_events = fwd_events + 32'd1;
      end
    end
    perf_fwd_d   = perf_fwd_q + fwd_events;
    perf_stall_d = perf_stall_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fwd_q   <= perf_fwd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fwd_cnt   = perf_fwd_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fwd_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
